serial_link_bringup_ctrl: RTL and testbench
===========================================

Name: serial_link_bringup_ctrl

Overview:
- Hardware sequencer that brings up one serial link instance over its register-bus configuration port, replacing the software start-up routine.
- Issues a fixed sequence of writes: link reset release and assert, clock enable, TX and RX channel-allocator config, settle wait, AXI de-isolation.
- Then polls the isolation status register until it reads zero.
- Sits between the SoC boot/control logic and the link's cfg port, one instance per link.

Parameters:
- AddrWidth, 32, register-bus address width.
- DataWidth, 32, register-bus data width; minimum 16.
- BaseAddr, 0, base address added to every offset.
- CtrlOffset, 'h0, link control register offset.
- IsolatedOffset, 'h4, isolation status register offset.
- TxCfgOffset, 'h10, TX channel-allocator config offset.
- RxCfgOffset, 'h14, RX channel-allocator config offset.
- SettleCycles, 50, idle clk_1 cycles between the RX config write and the de-isolate write; minimum 1.
- PollGapCycles, 4, idle cycles between consecutive status reads; 0 allowed.
- MaxPolls, 1024, number of status reads before timeout; minimum 1.

Ports:
- clk_1  in  1  clock.
- rst_1_n  in  1  reset, asynchronous, active-high.
- start_i  in  1  start request; sampled only in IDLE, DONE or ERROR.
- busy_o  out  1  sequence in progress.
- done_o  out  1  link ready; held until the next start or reset.
- error_o  out  1  sequence failed; held until the next start or reset.
- err_step_o  out  4  state index in which the failure occurred.
- poll_cnt_o  out  $clog2(MaxPolls+1)  status reads issued in the current run.
- cfg_valid_o  out  1  reg request valid.
- cfg_write_o  out  1  1 = write, 0 = read.
- cfg_addr_o  out  AddrWidth  request address.
- cfg_wdata_o  out  DataWidth  write data.
- cfg_wstrb_o  out  DataWidth/8  write strobe; all ones on writes, zero on reads.
- cfg_ready_i  in  1  slave accepts and completes the request.
- cfg_rdata_i  in  DataWidth  read data; valid while ready is high.
- cfg_error_i  in  1  slave error; valid while ready is high.

Behaviour:
Reset:
- All outputs 0; FSM to IDLE; counters cleared.
- Asserting reset mid-sequence abandons any outstanding request immediately.
- cfg_valid_o drops asynchronously; no completion is expected afterwards.

Handshake:
- Request outputs are registered and held stable from the cycle valid rises until the cycle where cfg_valid_o && cfg_ready_i; that cycle is the handshake.
- Valid never drops without a handshake, except on reset.
- cfg_rdata_i and cfg_error_i are sampled only on the handshake.

FSM states (index in err_step_o):
- IDLE(0)
- W_RSTREL(1): CTRL = 'h300
- W_RST(2): CTRL = 'h302
- W_CLKEN(3): CTRL = 'h303
- W_TXCFG(4): TXCFG = 'h3
- W_RXCFG(5): RXCFG = 'h3
- SETTLE(6)
- W_DEISO(7): CTRL = 'h03
- R_ISO(8)
- GAP(9)
- DONE(10)
- ERROR(11)

Transitions:
- IDLE/DONE/ERROR + start_i: go to W_RSTREL next cycle; clear done_o, error_o, err_step_o and poll_cnt_o; busy_o = 1.
- A write or read state drives cfg_valid_o in every cycle it is occupied.
- On handshake, go to the next state; if cfg_error_i = 1, go to ERROR with err_step_o = the current state index.
- SETTLE lasts exactly SettleCycles cycles, then W_DEISO.
- R_ISO handshake: poll_cnt_o increments.
  - rdata[1:0] == 0 → DONE.
  - Else, if poll_cnt_o (after increment) == MaxPolls → ERROR with err_step_o = 8.
  - Else → GAP.
- GAP lasts PollGapCycles cycles, then R_ISO. With PollGapCycles = 0, go directly back to R_ISO (next read on the following cycle).
- DONE: done_o = 1, busy_o = 0. ERROR: error_o = 1, busy_o = 0.
- start_i while busy_o = 1 is ignored; no queueing.
- Simultaneous error and rdata == 0 on the status read: error wins.
- Latency with a zero-wait slave and first read == 0: done_o rises SettleCycles + 7 cycles after the edge that samples start_i. Default: 57.

Test Plan:
- Zero-wait slave, status reads 0 → exactly 7 handshakes. Addresses/data in order: CTRL 'h300, 'h302, 'h303; TXCFG 'h3; RXCFG 'h3; CTRL 'h03; then a read of ISOLATED. done_o rises at cycle 57; poll_cnt_o = 1.
- Slave adds 3 wait cycles per request → request fields stable while valid && !ready; done_o rises at cycle 57 + 7×3 = 78.
- cfg_error_i on the W_CLKEN handshake → error_o = 1, err_step_o = 3, no further requests; start_i then restarts from the 'h300 write.
- Status reads 'h3, 'h1, 'h2, 'h0 → 4 reads with 4-cycle gaps between them; done_o = 1, poll_cnt_o = 4.
- MaxPolls = 8 and status stuck at 'h1 → exactly 8 reads, then error_o = 1, err_step_o = 8.
- rst_1_n pulsed during SETTLE, and a start_i pulse during W_TXCFG → all outputs 0 immediately on reset; the start pulse while busy has no effect on the sequence.

Source files
------------

// File: rtl/serial_link_bringup_ctrl.sv
// serial_link_bringup_ctrl: hardware sequencer that configures one serial link
// over its register-bus cfg port, then polls isolation status until clear.
module serial_link_bringup_ctrl #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter logic [AddrWidth-1:0] BaseAddr = '0,
  parameter logic [AddrWidth-1:0] CtrlOffset = 'h0,
  parameter logic [AddrWidth-1:0] IsolatedOffset = 'h4,
  parameter logic [AddrWidth-1:0] TxCfgOffset = 'h10,
  parameter logic [AddrWidth-1:0] RxCfgOffset = 'h14,
  parameter int unsigned SettleCycles = 50,
  parameter int unsigned PollGapCycles = 4,
  parameter int unsigned MaxPolls = 1024
) (
  input  logic                             clk_1,
  input  logic                             rst_1_n,
  input  logic                             start_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             error_o,
  output logic [3:0]                       err_step_o,
  output logic [$clog2(MaxPolls+1)-1:0]    poll_cnt_o,
  output logic                             cfg_valid_o,
  output logic                             cfg_write_o,
  output logic [AddrWidth-1:0]             cfg_addr_o,
  output logic [DataWidth-1:0]             cfg_wdata_o,
  output logic [DataWidth/8-1:0]           cfg_wstrb_o,
  input  logic                             cfg_ready_i,
  input  logic [DataWidth-1:0]             cfg_rdata_i,
  input  logic                             cfg_error_i
);
  localparam int unsigned PW = $clog2(MaxPolls + 1);
  localparam int unsigned CW = $clog2((SettleCycles > PollGapCycles ? SettleCycles : PollGapCycles) + 1);

  typedef enum logic [3:0] {
    IDLE = 4'd0, W_RSTREL = 4'd1, W_RST = 4'd2, W_CLKEN = 4'd3, W_TXCFG = 4'd4, W_RXCFG = 4'd5,
    SETTLE = 4'd6, W_DEISO = 4'd7, R_ISO = 4'd8, GAP = 4'd9, DONE = 4'd10, ERROR = 4'd11
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [3:0] err_step_q, err_step_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic valid_q, valid_d, write_q, write_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [DataWidth/8-1:0] wstrb_q, wstrb_d;
  logic hs;
  logic unused_rdata;

  assign hs = valid_q && cfg_ready_i;
  assign unused_rdata = ^cfg_rdata_i[DataWidth-1:2];

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    poll_cnt_d = poll_cnt_q;
    err_step_d = err_step_q;
    if (state_q inside {IDLE, DONE, ERROR}) begin
      if (start_i) begin
        state_d = W_RSTREL;
        poll_cnt_d = '0;
        err_step_d = '0;
      end
    end else if (state_q inside {SETTLE, GAP}) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) state_d = state_q == SETTLE ? W_DEISO : R_ISO;
    end else if (hs) begin
      poll_cnt_d = state_q == R_ISO ? poll_cnt_q + PW'(1) : poll_cnt_q;
      if (cfg_error_i) begin
        state_d = ERROR;
        err_step_d = state_q;
      end else if (state_q != R_ISO) state_d = state_t'(state_q + 4'd1);
      else if (cfg_rdata_i[1:0] == 2'b00) state_d = DONE;
      else if (poll_cnt_d == PW'(MaxPolls)) begin
        state_d = ERROR;
        err_step_d = state_q;
      end else state_d = PollGapCycles == 0 ? R_ISO : GAP;
      cnt_d = state_d == SETTLE ? CW'(SettleCycles - 1) : CW'(PollGapCycles - 1);
    end
    // Request fields follow the next state so they are registered with valid.
    valid_d = !(state_d inside {IDLE, SETTLE, GAP, DONE, ERROR});
    write_d = valid_d && state_d != R_ISO;
    addr_d = !valid_d ? '0 : BaseAddr + (state_d == R_ISO ? IsolatedOffset :
             state_d == W_TXCFG ? TxCfgOffset : state_d == W_RXCFG ? RxCfgOffset : CtrlOffset);
    wdata_d = state_d == W_RSTREL ? DataWidth'(32'h300) :
              state_d == W_RST ? DataWidth'(32'h302) :
              state_d == W_CLKEN ? DataWidth'(32'h303) :
              state_d inside {W_TXCFG, W_RXCFG, W_DEISO} ? DataWidth'(32'h3) : '0;
    wstrb_d = write_d ? '1 : '0;
    busy_d = valid_d || state_d inside {SETTLE, GAP};
    done_d = state_d == DONE;
    error_d = state_d == ERROR;
  end

  always_ff @(posedge clk_1 or posedge rst_1_n) begin
    if (rst_1_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      poll_cnt_q <= '0;
      err_step_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      poll_cnt_q <= poll_cnt_d;
      err_step_q <= err_step_d;
      busy_q <= busy_d;
      done_q <= done_d;
      error_q <= error_d;
      valid_q <= valid_d;
      write_q <= write_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign error_o = error_q;
  assign err_step_o = err_step_q;
  assign poll_cnt_o = poll_cnt_q;
  assign cfg_valid_o = valid_q;
  assign cfg_write_o = write_q;
  assign cfg_addr_o = addr_q;
  assign cfg_wdata_o = wdata_q;
  assign cfg_wstrb_o = wstrb_q;
endmodule

// File: tb/tb_serial_link_bringup_ctrl.sv
// tb_serial_link_bringup_ctrl: scenario-table bench with a scripted register slave
// that logs every handshake for comparison against the expected write sequence.
module tb_serial_link_bringup_ctrl;
  logic clk_1 = 1'b0;
  logic rst_1_n, start_i;
  logic busy_o, done_o, error_o;
  logic [3:0] err_step_o, poll_cnt_o;
  logic cfg_valid_o, cfg_write_o;
  logic [31:0] cfg_addr_o, cfg_wdata_o;
  logic [3:0] cfg_wstrb_o;
  logic cfg_ready_i, cfg_error_i;
  logic [31:0] cfg_rdata_i;

  serial_link_bringup_ctrl #(.MaxPolls(8)) dut (
    .clk_1(clk_1), .rst_1_n(rst_1_n), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .err_step_o(err_step_o), .poll_cnt_o(poll_cnt_o),
    .cfg_valid_o(cfg_valid_o), .cfg_write_o(cfg_write_o), .cfg_addr_o(cfg_addr_o),
    .cfg_wdata_o(cfg_wdata_o), .cfg_wstrb_o(cfg_wstrb_o),
    .cfg_ready_i(cfg_ready_i), .cfg_rdata_i(cfg_rdata_i), .cfg_error_i(cfg_error_i)
  );

  always #5 clk_1 = ~clk_1;

  typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct {
    int wait_c; int err_at; int nrd; logic [15:0] rds;
    int cyc; logic done; logic err; logic [3:0] step; int polls; int nhs;
  } scen_t;

  int checks = 0, errors = 0;
  int wait_c = 0, err_at = -1, nrd = 1, n_hs = 0, rd_idx = 0, stable_err = 0, wait_ctr = 0;
  logic [15:0] rds = '0;
  logic in_req = 1'b0;
  logic cur_wr;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0] cur_wstrb;
  logic hs_wr[64];
  logic [31:0] hs_addr[64], hs_wdata[64];
  logic [3:0] hs_wstrb[64];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic kick();
    @(negedge clk_1);
    start_i = 1'b1;
    @(negedge clk_1);
    start_i = 1'b0;
  endtask

  task automatic setup(input int w, input int e, input int n, input logic [15:0] r);
    wait_c = w; err_at = e; nrd = n; rds = r;
    n_hs = 0; rd_idx = 0; stable_err = 0;
  endtask

  task automatic run_to_end(output int cyc);
    cyc = 0;
    while (!done_o && !error_o && cyc < 3000) begin
      @(negedge clk_1);
      cyc++;
    end
  endtask

  // Scripted slave: decides ready at each negedge, logs completed handshakes.
  initial begin
    cfg_ready_i = 1'b0; cfg_error_i = 1'b0; cfg_rdata_i = '0;
    forever begin
      @(negedge clk_1);
      if (rst_1_n) begin
        cfg_ready_i = 1'b0; cfg_error_i = 1'b0; cfg_rdata_i = '0; in_req = 1'b0;
      end else begin
        if (cfg_ready_i) begin
          if (n_hs < 64) begin
            hs_wr[n_hs] = cur_wr; hs_addr[n_hs] = cur_addr;
            hs_wdata[n_hs] = cur_wdata; hs_wstrb[n_hs] = cur_wstrb;
          end
          if (!cur_wr) rd_idx++;
          n_hs++;
          in_req = 1'b0; cfg_ready_i = 1'b0; cfg_error_i = 1'b0; cfg_rdata_i = '0;
        end
        if (cfg_valid_o) begin
          if (!in_req) begin
            cur_wr = cfg_write_o; cur_addr = cfg_addr_o; cur_wdata = cfg_wdata_o; cur_wstrb = cfg_wstrb_o;
            in_req = 1'b1; wait_ctr = 0;
          end else if ({cfg_write_o, cfg_addr_o, cfg_wdata_o, cfg_wstrb_o} != {cur_wr, cur_addr, cur_wdata, cur_wstrb})
            stable_err++;
          if (wait_ctr == wait_c) begin
            int ri;
            ri = rd_idx < nrd ? rd_idx : nrd - 1;
            cfg_ready_i = 1'b1;
            cfg_error_i = n_hs == err_at;
            cfg_rdata_i = cur_wr ? 32'h0 : {28'h0, rds[4*ri +: 4]};
          end else wait_ctr++;
        end
      end
    end
  end

  initial begin
    req_t reqs[7];
    scen_t sc[6];
    int cyc;
    logic pulsed;
    reqs[0] = '{1'b1, 32'h0, 32'h300};
    reqs[1] = '{1'b1, 32'h0, 32'h302};
    reqs[2] = '{1'b1, 32'h0, 32'h303};
    reqs[3] = '{1'b1, 32'h10, 32'h3};
    reqs[4] = '{1'b1, 32'h14, 32'h3};
    reqs[5] = '{1'b1, 32'h0, 32'h3};
    reqs[6] = '{1'b0, 32'h4, 32'h0};
    sc[0] = '{0, -1, 1, 16'h0000, 57, 1'b1, 1'b0, 4'd0, 1, 7};
    sc[1] = '{3, -1, 1, 16'h0000, 78, 1'b1, 1'b0, 4'd0, 1, 7};
    sc[2] = '{0, 2, 1, 16'h0000, 3, 1'b0, 1'b1, 4'd3, 0, 3};
    sc[3] = '{0, -1, 4, 16'h0213, 72, 1'b1, 1'b0, 4'd0, 4, 10};
    sc[4] = '{0, -1, 1, 16'h0001, 92, 1'b0, 1'b1, 4'd8, 8, 14};
    sc[5] = '{0, 6, 1, 16'h0000, 57, 1'b0, 1'b1, 4'd8, 1, 7};
    rst_1_n = 1'b1;
    start_i = 1'b0;
    repeat (3) @(negedge clk_1);
    chk("reset_outputs", {busy_o, done_o, error_o, err_step_o, poll_cnt_o, cfg_valid_o,
        cfg_write_o, cfg_addr_o, cfg_wdata_o, cfg_wstrb_o}, '0);
    rst_1_n = 1'b0;
    repeat (2) @(negedge clk_1);
    for (int s = 0; s < 6; s++) begin
      setup(sc[s].wait_c, sc[s].err_at, sc[s].nrd, sc[s].rds);
      kick();
      run_to_end(cyc);
      chk($sformatf("s%0d_cycle", s), cyc, sc[s].cyc);
      repeat (5) @(negedge clk_1);
      chk($sformatf("s%0d_status", s), {busy_o, done_o, error_o, err_step_o},
          {1'b0, sc[s].done, sc[s].err, sc[s].step});
      chk($sformatf("s%0d_polls", s), poll_cnt_o, sc[s].polls);
      chk($sformatf("s%0d_handshakes", s), n_hs, sc[s].nhs);
      chk($sformatf("s%0d_stable", s), stable_err, 0);
      for (int j = 0; j < n_hs && j < 64; j++) begin
        req_t r;
        r = reqs[j < 7 ? j : 6];
        chk($sformatf("s%0d_req%0d", s, j), {hs_wr[j], hs_addr[j], hs_wdata[j], hs_wstrb[j]},
            {r.wr, r.addr, r.wdata, r.wr ? 4'hf : 4'h0});
      end
    end
    // start pulse while busy in W_TXCFG must not disturb the run
    setup(3, -1, 1, 16'h0);
    kick();
    cyc = 0;
    pulsed = 1'b0;
    while (!done_o && !error_o && cyc < 3000) begin
      @(negedge clk_1);
      cyc++;
      start_i = !pulsed && cfg_valid_o && cfg_addr_o == 32'h10;
      if (start_i) pulsed = 1'b1;
    end
    start_i = 1'b0;
    chk("busy_start_pulsed", pulsed, 1'b1);
    chk("busy_start_cycle", cyc, 78);
    chk("busy_start_handshakes", n_hs, 7);
    // reset during SETTLE
    setup(0, -1, 1, 16'h0);
    kick();
    repeat (20) @(negedge clk_1);
    chk("settle_busy", {busy_o, cfg_valid_o}, 2'b10);
    #2 rst_1_n = 1'b1;
    #1;
    chk("settle_async_reset", {busy_o, done_o, error_o, err_step_o, poll_cnt_o, cfg_valid_o,
        cfg_write_o, cfg_addr_o, cfg_wdata_o, cfg_wstrb_o}, '0);
    @(negedge clk_1);
    rst_1_n = 1'b0;
    repeat (60) @(negedge clk_1);
    chk("post_reset_idle", {busy_o, done_o, error_o, cfg_valid_o}, 4'b0000);
    // reset while a request is outstanding drops valid at once
    setup(3, -1, 1, 16'h0);
    kick();
    chk("req_outstanding", {cfg_valid_o, cfg_ready_i}, 2'b10);
    #2 rst_1_n = 1'b1;
    #1;
    chk("req_async_drop", {cfg_valid_o, busy_o, cfg_addr_o, cfg_wdata_o}, '0);
    @(negedge clk_1);
    rst_1_n = 1'b0;
    setup(0, -1, 1, 16'h0);
    kick();
    run_to_end(cyc);
    chk("rerun_cycle", cyc, 57);
    chk("rerun_done", {done_o, error_o, poll_cnt_o}, {1'b1, 1'b0, 4'd1});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
